tl_tx_arb: RTL and testbench

Transaction-layer TX arbiter sharing one outbound TLP path (128-bit header + 256-bit data beats) between two sources: the completion generator (CPL) and the request generator (REQ, MRd/MWr).
- Grants a source only when its flow-control credits are sufficient.
- Latches and forwards the header, then passes through the payload beats.
- Emits a credit-consume pulse to the credit manager.
- Sits between the TLP generators and the DLL-facing TX framer.

---
 rtl/tl_tx_arb_if.sv | 64 ++++++
 rtl/tl_tx_arb.sv | 155 +++++++++++++++
 tb/tb_tl_tx_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_tx_arb_if.sv
// Bundled handshake/bus signals between the CPL/REQ generators, credit inputs,
// the TX framer and tl_tx_arb. The master modport is the arbiter's view.
interface tl_tx_arb_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned HDR_W  = 128
);
  logic [HDR_W-1:0]  cpl_hdr_i;
  logic              cpl_hdr_valid_i;
  logic              cpl_hdr_ready_o;
  logic              cpl_has_data_i;
  logic [9:0]        cpl_len_dw_i;
  logic [DATA_W-1:0] cpl_data_i;
  logic              cpl_data_valid_i;
  logic              cpl_data_ready_o;

  logic [HDR_W-1:0]  req_hdr_i;
  logic              req_hdr_valid_i;
  logic              req_hdr_ready_o;
  logic              req_has_data_i;
  logic [9:0]        req_len_dw_i;
  logic [DATA_W-1:0] req_data_i;
  logic              req_data_valid_i;
  logic              req_data_ready_o;

  logic              cpl_cred_hdr_ok_i;
  logic              cpl_cred_data_ok_i;
  logic              req_cred_hdr_ok_i;
  logic              req_cred_data_ok_i;

  logic [HDR_W-1:0]  tx_hdr_o;
  logic              tx_hdr_valid_o;
  logic              tx_hdr_ready_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_data_valid_o;
  logic              tx_data_last_o;
  logic              tx_data_ready_i;
  logic              tx_src_o;

  logic              cred_consume_valid_o;
  logic              cred_consume_type_o;
  logic [10:0]       cred_consume_dw_o;

  modport master (
    input  cpl_hdr_i, cpl_hdr_valid_i, cpl_has_data_i, cpl_len_dw_i, cpl_data_i, cpl_data_valid_i,
    output cpl_hdr_ready_o, cpl_data_ready_o,
    input  req_hdr_i, req_hdr_valid_i, req_has_data_i, req_len_dw_i, req_data_i, req_data_valid_i,
    output req_hdr_ready_o, req_data_ready_o,
    input  cpl_cred_hdr_ok_i, cpl_cred_data_ok_i, req_cred_hdr_ok_i, req_cred_data_ok_i,
    output tx_hdr_o, tx_hdr_valid_o, tx_data_o, tx_data_valid_o, tx_data_last_o, tx_src_o,
    input  tx_hdr_ready_i, tx_data_ready_i,
    output cred_consume_valid_o, cred_consume_type_o, cred_consume_dw_o
  );

  modport slave (
    output cpl_hdr_i, cpl_hdr_valid_i, cpl_has_data_i, cpl_len_dw_i, cpl_data_i, cpl_data_valid_i,
    input  cpl_hdr_ready_o, cpl_data_ready_o,
    output req_hdr_i, req_hdr_valid_i, req_has_data_i, req_len_dw_i, req_data_i, req_data_valid_i,
    input  req_hdr_ready_o, req_data_ready_o,
    output cpl_cred_hdr_ok_i, cpl_cred_data_ok_i, req_cred_hdr_ok_i, req_cred_data_ok_i,
    input  tx_hdr_o, tx_hdr_valid_o, tx_data_o, tx_data_valid_o, tx_data_last_o, tx_src_o,
    output tx_hdr_ready_i, tx_data_ready_i,
    input  cred_consume_valid_o, cred_consume_type_o, cred_consume_dw_o
  );
endinterface

// File: rtl/tl_tx_arb.sv
// TX arbiter: credit-gated CPL/REQ grant, header latch, payload pass-through.
// Define TL_TX_ARB_CPL_PRIO_EN for CPL strict priority with REQ starvation relief.
module tl_tx_arb #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned HDR_W      = 128,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  tl_tx_arb_if.master  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic              has_data_q, has_data_d;
  logic              src_q, src_d;
  logic [9:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              elig_cpl, elig_req, grant, win;
  logic [10:0]       len_eff, beats;
  logic [7:0]        last_idx;
  logic              own_valid;
  logic [DATA_W-1:0] own_data;

  assign elig_cpl = bus.cpl_hdr_valid_i && bus.cpl_cred_hdr_ok_i &&
                    (!bus.cpl_has_data_i || bus.cpl_cred_data_ok_i);
  assign elig_req = bus.req_hdr_valid_i && bus.req_cred_hdr_ok_i &&
                    (!bus.req_has_data_i || bus.req_cred_data_ok_i);
  assign grant    = (state_q == IDLE) && (elig_cpl || elig_req) && !rst;

  assign len_eff   = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
  assign beats     = (len_eff + 11'd7) >> 3;
  assign last_idx  = beats[7:0] - 8'd1;
  assign own_valid = src_q ? bus.req_data_valid_i : bus.cpl_data_valid_i;
  assign own_data  = src_q ? bus.req_data_i : bus.cpl_data_i;

`ifdef TL_TX_ARB_CPL_PRIO_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starved;

  // Counts CPL wins only while REQ was actually competing; saturates.
  assign starved = (starve_q >= STARVE_W'(STARVE_MAX));
  assign win     = elig_req && (!elig_cpl || starved);

  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (win)                      starve_d = '0;
      else if (elig_req && !starved) starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic rr_q, rr_d;

  // rr_q is the favoured source on a tie: 0 = CPL, 1 = REQ.
  assign win = elig_req && (!elig_cpl || rr_q);

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = !win;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    has_data_d = has_data_q;
    src_d      = src_q;
    len_d      = len_q;
    cnt_d      = cnt_q;

    bus.cpl_hdr_ready_o      = 1'b0;
    bus.req_hdr_ready_o      = 1'b0;
    bus.cpl_data_ready_o     = 1'b0;
    bus.req_data_ready_o     = 1'b0;
    bus.tx_hdr_o             = hdr_q;
    bus.tx_hdr_valid_o       = 1'b0;
    bus.tx_data_o            = '0;
    bus.tx_data_valid_o      = 1'b0;
    bus.tx_data_last_o       = 1'b0;
    bus.tx_src_o             = src_q;
    bus.cred_consume_valid_o = 1'b0;
    bus.cred_consume_type_o  = src_q;
    bus.cred_consume_dw_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          bus.cpl_hdr_ready_o = !win;
          bus.req_hdr_ready_o = win;
          hdr_d      = win ? bus.req_hdr_i      : bus.cpl_hdr_i;
          has_data_d = win ? bus.req_has_data_i : bus.cpl_has_data_i;
          len_d      = win ? bus.req_len_dw_i   : bus.cpl_len_dw_i;
          src_d      = win;
          state_d    = HDR;
        end
      end
      HDR: begin
        bus.tx_hdr_valid_o = 1'b1;
        if (bus.tx_hdr_ready_i) begin
          bus.cred_consume_valid_o = 1'b1;
          bus.cred_consume_dw_o    = has_data_q ? len_eff : '0;
          state_d                  = has_data_q ? DATA : IDLE;
        end
      end
      DATA: begin
        bus.tx_data_o       = own_data;
        bus.tx_data_valid_o = own_valid;
        bus.tx_data_last_o  = (cnt_q == last_idx) && own_valid;
        if (src_q) bus.req_data_ready_o = bus.tx_data_ready_i;
        else       bus.cpl_data_ready_o = bus.tx_data_ready_i;
        if (own_valid && bus.tx_data_ready_i) begin
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      has_data_q <= 1'b0;
      src_q      <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      has_data_q <= has_data_d;
      src_q      <= src_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tl_tx_arb.sv
// Directed scoreboard bench for tl_tx_arb: source models feed TLPs, expected
// grants, headers, consume pulses and data beats are queued and matched per cycle.
module tb_tl_tx_arb;
  typedef struct {
    logic [127:0] hdr;
    logic         has_data;
    logic [9:0]   len;
    logic [7:0]   tag;
  } tlp_t;

  typedef struct {
    logic         src;
    logic [127:0] hdr;
    logic [10:0]  dw;
  } hexp_t;

  typedef struct {
    logic [255:0] data;
    logic         last;
  } bexp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_tx_arb_if #(.DATA_W(256), .HDR_W(128)) bus ();

  tl_tx_arb #(.DATA_W(256), .HDR_W(128), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tlp_t        srcq [2][$];
  bit          in_data [2];
  int unsigned beat [2];
  hexp_t       exp_hdr [$];
  bexp_t       exp_beat [$];
  bit          exp_grant [$];

  int          checks = 0;
  int          errors = 0;
  int          beats_seen = 0;
  logic [7:0]  tag_ctr = 8'd1;
  logic        hdr_rdy, data_rdy;
  bit          toggle;
  logic        cred_hdr [2];
  logic        cred_data [2];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbeats(input logic [9:0] len);
    int unsigned eff;
    eff = (len == 10'd0) ? 1024 : int'(len);
    return (eff + 7) / 8;
  endfunction

  function automatic logic [255:0] beat_data(input logic s, input logic [7:0] tag, input int unsigned idx);
    logic [31:0] w;
    w = {(s ? 8'hB5 : 8'h3C), tag, 16'(idx)};
    return {w, ~w, w, ~w, w, ~w, w, ~w};
  endfunction

  function automatic tlp_t front(input int s);
    tlp_t t;
    t.hdr = '0; t.has_data = 1'b0; t.len = '0; t.tag = '0;
    if (srcq[s].size() > 0) t = srcq[s][0];
    return t;
  endfunction

  function automatic bit done();
    return srcq[0].size() == 0 && srcq[1].size() == 0 && exp_hdr.size() == 0 &&
           exp_beat.size() == 0 && exp_grant.size() == 0;
  endfunction

  task automatic add_tlp(input int s, input bit hd, input logic [9:0] len);
    tlp_t t;
    t.hdr      = {$urandom(), $urandom(), $urandom(), 24'hA5A5A5, tag_ctr};
    t.has_data = hd;
    t.len      = len;
    t.tag      = tag_ctr;
    tag_ctr++;
    srcq[s].push_back(t);
  endtask

  task automatic drive();
    tlp_t c, r;
    c = front(0);
    r = front(1);
    bus.cpl_hdr_i          = c.hdr;
    bus.cpl_hdr_valid_i    = (srcq[0].size() > 0) && !in_data[0];
    bus.cpl_has_data_i     = c.has_data;
    bus.cpl_len_dw_i       = c.len;
    bus.cpl_data_valid_i   = in_data[0];
    bus.cpl_data_i         = in_data[0] ? beat_data(1'b0, c.tag, beat[0]) : '0;
    bus.req_hdr_i          = r.hdr;
    bus.req_hdr_valid_i    = (srcq[1].size() > 0) && !in_data[1];
    bus.req_has_data_i     = r.has_data;
    bus.req_len_dw_i       = r.len;
    bus.req_data_valid_i   = in_data[1];
    bus.req_data_i         = in_data[1] ? beat_data(1'b1, r.tag, beat[1]) : '0;
    bus.cpl_cred_hdr_ok_i  = cred_hdr[0];
    bus.cpl_cred_data_ok_i = cred_data[0];
    bus.req_cred_hdr_ok_i  = cred_hdr[1];
    bus.req_cred_data_ok_i = cred_data[1];
    bus.tx_hdr_ready_i     = hdr_rdy;
    bus.tx_data_ready_i    = data_rdy;
  endtask

  // One cycle: drive at negedge, observe the handshakes of the coming posedge.
  task automatic tick();
    logic g [2];
    logic dr [2];
    bit dph;
    hexp_t he;
    bexp_t be;
    tlp_t t;
    int unsigned nb;
    @(negedge clk);
    drive();
    #1;
    g[0]  = bus.cpl_hdr_ready_o;
    g[1]  = bus.req_hdr_ready_o;
    dr[0] = bus.cpl_data_ready_o;
    dr[1] = bus.req_data_ready_o;
    dph   = (exp_hdr.size() == 0) && (exp_beat.size() > 0);

    check("tx_hdr_valid", 256'(bus.tx_hdr_valid_o), 256'(exp_hdr.size() > 0));
    check("cons_valid", 256'(bus.cred_consume_valid_o), 256'((exp_hdr.size() > 0) && hdr_rdy));
    if (exp_hdr.size() > 0) begin
      he = exp_hdr[0];
      check("tx_hdr", 256'(bus.tx_hdr_o), 256'(he.hdr));
      check("tx_src", 256'(bus.tx_src_o), 256'(he.src));
      if (hdr_rdy) begin
        check("cons_type", 256'(bus.cred_consume_type_o), 256'(he.src));
        check("cons_dw", 256'(bus.cred_consume_dw_o), 256'(he.dw));
        void'(exp_hdr.pop_front());
      end
    end

    check("tx_data_valid", 256'(bus.tx_data_valid_o), 256'(dph));
    check("cpl_data_ready", 256'(dr[0]), 256'((dph && in_data[0]) ? data_rdy : 1'b0));
    check("req_data_ready", 256'(dr[1]), 256'((dph && in_data[1]) ? data_rdy : 1'b0));
    if (dph) begin
      be = exp_beat[0];
      check("tx_data", bus.tx_data_o, be.data);
      check("tx_data_last", 256'(bus.tx_data_last_o), 256'(be.last));
      if (data_rdy && bus.tx_data_valid_o) begin
        void'(exp_beat.pop_front());
        beats_seen++;
      end
    end else begin
      check("tx_data_last_idle", 256'(bus.tx_data_last_o), 256'(0));
    end

    for (int s = 0; s < 2; s++) begin
      if (in_data[s] && dr[s] && srcq[s].size() > 0) begin
        t = srcq[s][0];
        beat[s]++;
        if (beat[s] == nbeats(t.len)) begin
          in_data[s] = 1'b0;
          void'(srcq[s].pop_front());
        end
      end
    end

    check("grant_onehot", 256'(g[0] && g[1]), 256'(0));
    for (int s = 0; s < 2; s++) begin
      if (g[s]) begin
        check("grant_expected", 256'(exp_grant.size() > 0), 256'(1));
        if (exp_grant.size() > 0) check("grant_src", 256'(s), 256'(exp_grant.pop_front()));
        if (srcq[s].size() > 0 && !in_data[s]) begin
          t      = srcq[s][0];
          he.src = 1'(s);
          he.hdr = t.hdr;
          he.dw  = t.has_data ? ((t.len == 10'd0) ? 11'd1024 : {1'b0, t.len}) : 11'd0;
          exp_hdr.push_back(he);
          if (t.has_data) begin
            nb = nbeats(t.len);
            for (int unsigned i = 0; i < nb; i++) begin
              be.data = beat_data(1'(s), t.tag, i);
              be.last = (i == nb - 1);
              exp_beat.push_back(be);
            end
            in_data[s] = 1'b1;
            beat[s]    = 0;
          end else begin
            void'(srcq[s].pop_front());
          end
        end
      end
    end

    if (toggle) data_rdy = !data_rdy;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done() && n < budget) begin
      tick();
      n++;
    end
    check({tag, " completion"}, 256'(done()), 256'(1));
  endtask

  task automatic clear_model();
    srcq[0].delete();
    srcq[1].delete();
    exp_hdr.delete();
    exp_beat.delete();
    exp_grant.delete();
    in_data[0] = 1'b0; in_data[1] = 1'b0;
    beat[0] = 0; beat[1] = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " hdr_valid"}, 256'(bus.tx_hdr_valid_o), 256'(0));
    check({tag, " data_valid"}, 256'(bus.tx_data_valid_o), 256'(0));
    check({tag, " data_last"}, 256'(bus.tx_data_last_o), 256'(0));
    check({tag, " hdr_ready"}, 256'({bus.cpl_hdr_ready_o, bus.req_hdr_ready_o}), 256'(0));
    check({tag, " data_ready"}, 256'({bus.cpl_data_ready_o, bus.req_data_ready_o}), 256'(0));
    check({tag, " tx_hdr"}, 256'(bus.tx_hdr_o), 256'(0));
    check({tag, " tx_src"}, 256'(bus.tx_src_o), 256'(0));
    check({tag, " cons_valid"}, 256'(bus.cred_consume_valid_o), 256'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    tick();
    check_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int b0;
    rst = 1'b1;
    hdr_rdy = 1'b1; data_rdy = 1'b1; toggle = 1'b0;
    cred_hdr[0] = 1'b1; cred_hdr[1] = 1'b1;
    cred_data[0] = 1'b1; cred_data[1] = 1'b1;
    clear_model();
    drive();
    tick();
    check_zero("reset");
    rst = 1'b0;

    // CPL header only, sink holds off the header for a few cycles.
    hdr_rdy = 1'b0;
    add_tlp(0, 1'b0, 10'd0);
    exp_grant.push_back(1'b0);
    run_cycles(4);
    hdr_rdy = 1'b1;
    run_until_done(50, "cpl_nodata");

    // REQ MWr of 20 DW: three beats.
    b0 = beats_seen;
    add_tlp(1, 1'b1, 10'd20);
    exp_grant.push_back(1'b1);
    run_until_done(100, "req_mwr20");
    check("req_mwr20 beats", 256'(beats_seen - b0), 256'(3));

    // Both sources saturated, four TLPs each, from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_tlp(0, 1'b0, 10'd0);
      add_tlp(1, 1'b0, 10'd0);
    end
`ifdef TL_TX_ARB_CPL_PRIO_EN
    for (int i = 0; i < 4; i++) exp_grant.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_grant.push_back(1'b1);
`else
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
    end
`endif
    run_until_done(200, "alternate");

    // CPL blocked on data credit while REQ goes through.
    cred_data[0] = 1'b0;
    add_tlp(0, 1'b1, 10'd8);
    add_tlp(1, 1'b0, 10'd0);
    exp_grant.push_back(1'b1);
    run_cycles(20);
    check("credit_block req_sent", 256'(srcq[1].size()), 256'(0));
    check("credit_block cpl_held", 256'(srcq[0].size()), 256'(1));
    check("credit_block grants", 256'(exp_grant.size()), 256'(0));
    cred_data[0] = 1'b1;
    exp_grant.push_back(1'b0);
    run_until_done(100, "credit_return");

    // 1024-DW CPLD under toggling sink ready.
    b0 = beats_seen;
    toggle = 1'b1;
    add_tlp(0, 1'b1, 10'd0);
    exp_grant.push_back(1'b0);
    run_until_done(1000, "cpld_1024");
    check("cpld_1024 beats", 256'(beats_seen - b0), 256'(128));
    toggle = 1'b0;
    data_rdy = 1'b1;

    // Reset in the middle of a 5-beat payload.
    add_tlp(1, 1'b1, 10'd40);
    exp_grant.push_back(1'b1);
    for (int i = 0; i < 60 && !(in_data[1] && beat[1] == 2); i++) tick();
    check("mid_rst reached beat 2", 256'(in_data[1] && beat[1] == 2), 256'(1));
    rst = 1'b1;
    clear_model();
    tick();
    check_zero("mid_rst");
    rst = 1'b0;
    add_tlp(1, 1'b0, 10'd0);
    exp_grant.push_back(1'b1);
    run_until_done(50, "post_rst");

    // Long CPL burst against a short REQ burst.
    do_reset();
    for (int i = 0; i < 8; i++) add_tlp(0, 1'b0, 10'd0);
    for (int i = 0; i < 2; i++) add_tlp(1, 1'b0, 10'd0);
`ifdef TL_TX_ARB_CPL_PRIO_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
    end
`else
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    for (int i = 0; i < 6; i++) exp_grant.push_back(1'b0);
`endif
    run_until_done(200, "burst_order");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
